// File: rtl/enc_4x2_serial.sv
// enc_4x2_serial: serialises a request vector into the indices of its set bits, lowest index first
module enc_4x2_serial #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [0:0]       state;
  logic [N-1:0]     pend;
  logic [IDX_W-1:0] lo;
  logic             one;
  // lowest set bit of pend and whether it is the only one left
  always_comb begin
    lo = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pend[i]) lo = IDX_W'(i);
    one = (pend != '0) && ((pend & (pend - N'(1))) == '0);
  end
  // handshake and output signals are forced low while reset is held
  always_comb begin
    in_ready  = !rst && state == IDLE;
    out_valid = !rst && state == SEND;
    out_idx   = out_valid ? lo : '0;
    out_last  = out_valid && one;
  end
  // capture in IDLE, retire the lowest pending bit on each output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= state == IDLE && in_valid && in == '0;
      if (state == IDLE && in_valid && in != '0) begin
        pend  <= in;
        state <= SEND;
      end else if (state == SEND && out_ready) begin
        pend  <= pend & (pend - N'(1));
        state <= one ? IDLE : SEND;
      end
    end
  end
endmodule

// File: tb/tb_enc_4x2_serial.sv
// tb_enc_4x2_serial: scoreboard bench for the serial 4-to-2 encoder
module tb_enc_4x2_serial;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in = 4'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_idx;
  logic       out_last;
  logic       zero_err;
  int         total = 0;
  int         bad = 0;
  logic [2:0] q[$];

  enc_4x2_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic last);
    q.push_back({idx, last});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, {7'b0, in_ready}, 8'h01);
  endtask

  task automatic send(input logic [3:0] v);
    wait_idle("ready_before_send");
    in_valid = 1'b1;
    in = v;
    tick();
    in_valid = 1'b0;
    in = 4'b0;
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst) begin
      check("zero_err_vs_valid", {7'b0, zero_err && out_valid}, 8'h00);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", {5'b0, out_idx, out_last}, 8'hff);
        end else begin
          e = q.pop_front();
          check("out_idx_last", {5'b0, out_idx, out_last}, {5'b0, e});
        end
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_in_ready", {7'b0, in_ready}, 8'h00);
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_out_idx", {6'b0, out_idx}, 8'h00);
    check("rst_out_last", {7'b0, out_last}, 8'h00);
    check("rst_zero_err", {7'b0, zero_err}, 8'h00);
    rst = 1'b0;
    #1;
    check("release_in_ready", {7'b0, in_ready}, 8'h01);

    push(2'd2, 1'b1);
    send(4'b0100);
    check("t2_valid", {7'b0, out_valid}, 8'h01);
    check("t2_idx", {6'b0, out_idx}, 8'h02);
    check("t2_last", {7'b0, out_last}, 8'h01);
    check("t2_busy", {7'b0, in_ready}, 8'h00);
    tick();
    check("t2_ready_after", {7'b0, in_ready}, 8'h01);

    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd3, 1'b1);
    send(4'b1011);
    tick();
    tick();
    tick();
    check("t3_ready_after", {7'b0, in_ready}, 8'h01);

    out_ready = 1'b0;
    push(2'd1, 1'b0);
    push(2'd2, 1'b1);
    send(4'b0110);
    in_valid = 1'b1;
    in = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_valid", {7'b0, out_valid}, 8'h01);
      check("t4_hold_idx", {6'b0, out_idx}, 8'h01);
      check("t4_hold_last", {7'b0, out_last}, 8'h00);
      tick();
    end
    in_valid = 1'b0;
    in = 4'b0;
    out_ready = 1'b1;
    wait_idle("t4_done");

    send(4'b0000);
    check("t5_zero_err", {7'b0, zero_err}, 8'h01);
    check("t5_no_valid", {7'b0, out_valid}, 8'h00);
    tick();
    check("t5_zero_err_pulse", {7'b0, zero_err}, 8'h00);
    check("t5_no_valid2", {7'b0, out_valid}, 8'h00);

    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b1);
    send(4'b1111);
    tick();
    rst = 1'b1;
    q.delete();
    push(2'd0, 1'b0);
    q.delete();
    tick();
    check("t6_rst_valid", {7'b0, out_valid}, 8'h00);
    check("t6_rst_ready", {7'b0, in_ready}, 8'h00);
    rst = 1'b0;
    tick();
    check("t6_rel_ready", {7'b0, in_ready}, 8'h01);
    check("t6_rel_valid", {7'b0, out_valid}, 8'h00);
    push(2'd3, 1'b1);
    send(4'b1000);
    wait_idle("t6_done");

    for (int k = 0; k < 4; k++) begin
      logic [3:0] v;
      v = 4'b0001 << k;
      push(2'(k), 1'b1);
      send(v);
      check("t7_idx", {6'b0, out_idx}, 8'(k));
      wait_idle("t7_done");
    end

    tick();
    tick();
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
